ftdi_fifo_port: RTL

Byte-wide handshake engine between the FPGA core and the FTDI FIFO-mode USB bridge. It drives the FTDI read and write strobes (`rd_n`, `wr_n`), owns the shared 8-bit ADBUS and its turnaround, and arbitrates between host-to-FPGA reads and FPGA-to-host writes. It sits directly upstream of the packet/sequence logic in `main` (START/STOP/ACK/DONE framing), which it feeds with a valid/ready byte stream and from which it accepts outbound bytes.

---
 rtl/ftdi_fifo_port.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ftdi_fifo_port.sv
// Byte-wide strobe engine for the FTDI FIFO-mode bridge: reads host bytes, writes core bytes, owns ADBUS turnaround.
// Latency: rxf_n fall -> rd_n fall SYNC_STAGES+1 cycles, rd_n fall -> rx_valid RD_LOW_CYC; tx load -> wr_n fall 2 cycles.
// Backpressure: no read starts while rx_valid is held (rx_ready low); tx_ready stays low until the held byte is written.
//
// Ports:
//   clock, resetN        : core clock, asynchronous active-low reset
//   rxf_n, txe_n         : FTDI status flags (asynchronous, active low)
//   rd_n, wr_n           : FTDI strobes (registered, active low)
//   adbus_in/out/oe      : shared ADBUS pad split into sample, drive value and drive enable
//   rx_data/valid/ready  : received byte stream toward the packet logic
//   tx_data/valid/ready  : outbound byte stream from the packet logic
module ftdi_fifo_port #(
  parameter int SYNC_STAGES  = 2,
  parameter int RD_LOW_CYC   = 4,
  parameter int RD_HIGH_CYC  = 3,
  parameter int WR_SETUP_CYC = 1,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 3
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       rxf_n,
  input  logic       txe_n,
  output logic       rd_n,
  output logic       wr_n,
  input  logic [7:0] adbus_in,
  output logic [7:0] adbus_out,
  output logic       adbus_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LOW,
    S_RD_HIGH,
    S_WR_SETUP,
    S_WR_LOW,
    S_WR_HIGH
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] rxf_sync;
  logic [SYNC_STAGES-1:0] txe_sync;
  logic                   rxf_s;
  logic                   txe_s;
  logic                   tx_full;
  logic [7:0]             tx_reg;
  logic                   last_grant_wr;
  logic                   rd_ok;
  logic                   wr_ok;

  // Flag synchronizers; idle value is "not ready" so reset never fakes a request.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rxf_sync <= '1;
      txe_sync <= '1;
    end else begin
      rxf_sync[0] <= rxf_n;
      txe_sync[0] <= txe_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rxf_sync[i] <= rxf_sync[i-1];
        txe_sync[i] <= txe_sync[i-1];
      end
    end
  end

  assign rxf_s    = rxf_sync[SYNC_STAGES-1];
  assign txe_s    = txe_sync[SYNC_STAGES-1];
  assign rd_ok    = ~rxf_s & ~rx_valid;
  assign wr_ok    = ~txe_s & tx_full;
  assign tx_ready = ~tx_full;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      cnt           <= '0;
      rd_n          <= 1'b1;
      wr_n          <= 1'b1;
      adbus_oe      <= 1'b0;
      adbus_out     <= 8'h00;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      tx_full       <= 1'b0;
      tx_reg        <= 8'h00;
      last_grant_wr <= 1'b1;
    end else begin
      // TX holding register load; cannot collide with the WR_LOW exit clear below.
      if (tx_valid && !tx_full) begin
        tx_full <= 1'b1;
        tx_reg  <= tx_data;
      end

      // Consumer handshake; a capture later in this block takes priority.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          // Tie goes to whichever side was not served last.
          if (rd_ok && (!wr_ok || last_grant_wr)) begin
            state         <= S_RD_LOW;
            rd_n          <= 1'b0;
            cnt           <= CW'(RD_LOW_CYC - 1);
            last_grant_wr <= 1'b0;
          end else if (wr_ok) begin
            state         <= S_WR_SETUP;
            adbus_oe      <= 1'b1;
            adbus_out     <= tx_reg;
            cnt           <= CW'(WR_SETUP_CYC - 1);
            last_grant_wr <= 1'b1;
          end
        end

        S_RD_LOW: begin
          if (cnt == '0) begin
            state    <= S_RD_HIGH;
            rd_n     <= 1'b1;
            rx_data  <= adbus_in;
            rx_valid <= 1'b1;
            cnt      <= CW'(RD_HIGH_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_RD_HIGH: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end

        S_WR_SETUP: begin
          if (cnt == '0) begin
            state <= S_WR_LOW;
            wr_n  <= 1'b0;
            cnt   <= CW'(WR_LOW_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_WR_LOW: begin
          if (cnt == '0) begin
            // Data stays driven one more cycle past the rising strobe for hold.
            state   <= S_WR_HIGH;
            wr_n    <= 1'b1;
            tx_full <= 1'b0;
            cnt     <= CW'(WR_HIGH_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_WR_HIGH: begin
          adbus_oe <= 1'b0;
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          rd_n     <= 1'b1;
          wr_n     <= 1'b1;
          adbus_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
